encoder_using_priority_casez: RTL and testbench
===============================================

// Module: encoder_using_priority_casez
// PURPOSE
//  Sequential priority encoder; the inverse of the 4->16 decoder test block.
//  - Accepts a 16-bit request vector through a valid/ready handshake.
//  - Emits one 4-bit binary code per set bit, in priority order.
//  - Clears each bit once its code is consumed.
//  - Exercises priority casez inside clocked logic for triplication tests.
// PARAMETERS
//  LOW_FIRST  1  1: bit 0 has highest priority (ascending codes); 0: bit 15 highest (descending)
// PORTS
//  clk        input   1   system clock, all logic on rising edge
//  rst        input   1   synchronous reset, active-high
//  req_in     input   16  request vector
//  in_valid   input   1   req_in valid
//  in_ready   output  1   block can accept req_in
//  code_out   output  4   binary index of highest-priority pending bit
//  out_valid  output  1   code_out valid
//  out_ready  input   1   consumer accepts code_out
//  out_last   output  1   code_out is the final code of the current vector
//  zero_drop  output  1   one-cycle pulse: an all-zero vector was accepted and dropped
//  code_par   output  1   even parity of code_out (only with ENCODER_PARITY_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, pend=0, code_out=0, out_valid=0, out_last=0,
//    zero_drop=0. in_ready=0 while rst is high and 1 in the first cycle after release.
//  - FSM states:
//    IDLE: in_ready=1, out_valid=0.
//      in_valid & req_in!=0: pend<=req_in, go to SCAN.
//      in_valid & req_in==0: stay in IDLE, zero_drop=1 next cycle only.
//    SCAN: in_ready=0, out_valid=1.
//      code_out = priority casez encode of pend (per LOW_FIRST).
//      out_last = 1 when pend has exactly one bit set.
//      out_valid & out_ready: clear bit code_out in pend.
//        If out_last: go to IDLE. Otherwise stay in SCAN with the next code.
//  - Latency: vector accepted at edge N, first code valid from edge N+1.
//    A k-bit vector takes k cycles in SCAN plus 1 IDLE cycle before the next accept.
//  - No overlap: a new vector is never accepted in the cycle the last code is consumed.
//  - Backpressure: while out_ready=0, code_out, out_last and pend hold stable.
//  - in_valid in SCAN is ignored; no capture occurs.
//  - Codes are 4-bit unsigned with no wrap: 15 is the maximum. Duplicate codes per vector are impossible.
//  - Reset mid-SCAN: pending bits are discarded. Outputs return to reset values the next cycle. No partial code is emitted.
//  - pend is never zero in SCAN. If corrupted to zero, FSM returns to IDLE and emits no output.
// CONFIGURATION
//  ENCODER_PARITY_EN defined:
//    - Adds port code_par = ^code_out, aligned with code_out.
//    - code_par is 0 in reset and whenever out_valid=0.
//  ENCODER_PARITY_EN undefined:
//    - code_par port and its logic are absent.
//    - All other behaviour is identical.
// TESTING
//  1 Reset: hold rst 2 cycles then release.
//    -> out_valid=0, code_out=0, zero_drop=0; in_ready=1 on the first cycle after release.
//  2 Single bit: req_in=16'h0001, out_ready=1.
//    -> exactly one token code_out=4'h0, out_last=1; in_ready=1 on the following cycle.
//  3 Multi-bit: req_in=16'h8421, LOW_FIRST=1, out_ready=1.
//    -> codes 0,5,10,15 on 4 consecutive cycles; out_last only on 15.
//    -> With the macro, code_par=0,0,0,0. With LOW_FIRST=0, order is 15,10,5,0.
//  4 Backpressure: req_in=16'h0300, out_ready=0 for 3 cycles then 1.
//    -> code_out=8 held stable 4 cycles, then 9 with out_last=1.
//  5 Zero vector: req_in=16'h0000, in_valid=1 for 1 cycle.
//    -> zero_drop=1 for exactly 1 cycle; out_valid stays 0; in_ready stays 1.
//  6 Reset mid-scan: req_in=16'hFFFF, consume 3 codes (0,1,2), pulse rst, then req_in=16'h0010.
//    -> out_valid=0 after rst; next token is code 4 with out_last=1.

Source files
------------

// File: rtl/encoder_using_priority_casez.sv
`default_nettype none
// ============================================================================
// Module      : encoder_using_priority_casez
// Description : Sequential priority encoder. Accepts a 16-bit request vector
//               through a valid/ready handshake, then emits one 4-bit code
//               per set bit in priority order. Each bit is cleared when its
//               code is consumed. LOW_FIRST selects ascending (bit 0 first)
//               or descending (bit 15 first) order.
//               Optional macro ENCODER_PARITY_EN adds the code_par output
//               (even parity of code_out).
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_using_priority_casez #(
    parameter int LOW_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  code_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        zero_drop
`ifdef ENCODER_PARITY_EN
    ,
    output logic        code_par
`endif
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_scan = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_pend;
    logic [15:0] w_pend_nxt;
    logic        r_zero_drop;
    logic        w_zero_drop_nxt;

    logic [3:0]  w_code;
    logic [15:0] w_clear_mask;
    logic        w_pend_nz;
    logic        w_single;
    logic        w_fire;

    // Priority encode of the pending vector; the branch fixes which end wins.
    generate
        if (LOW_FIRST != 0) begin : g_low_first
            // Lowest set bit of the pending vector.
            always_comb begin
                w_code = 4'd0;
                priority casez (r_pend)
                    16'b????_????_????_???1: w_code = 4'd0;
                    16'b????_????_????_??10: w_code = 4'd1;
                    16'b????_????_????_?100: w_code = 4'd2;
                    16'b????_????_????_1000: w_code = 4'd3;
                    16'b????_????_???1_0000: w_code = 4'd4;
                    16'b????_????_??10_0000: w_code = 4'd5;
                    16'b????_????_?100_0000: w_code = 4'd6;
                    16'b????_????_1000_0000: w_code = 4'd7;
                    16'b????_???1_0000_0000: w_code = 4'd8;
                    16'b????_??10_0000_0000: w_code = 4'd9;
                    16'b????_?100_0000_0000: w_code = 4'd10;
                    16'b????_1000_0000_0000: w_code = 4'd11;
                    16'b???1_0000_0000_0000: w_code = 4'd12;
                    16'b??10_0000_0000_0000: w_code = 4'd13;
                    16'b?100_0000_0000_0000: w_code = 4'd14;
                    16'b1000_0000_0000_0000: w_code = 4'd15;
                    default:                 w_code = 4'd0;
                endcase
            end
        end else begin : g_high_first
            // Highest set bit of the pending vector.
            always_comb begin
                w_code = 4'd0;
                priority casez (r_pend)
                    16'b1???_????_????_????: w_code = 4'd15;
                    16'b01??_????_????_????: w_code = 4'd14;
                    16'b001?_????_????_????: w_code = 4'd13;
                    16'b0001_????_????_????: w_code = 4'd12;
                    16'b0000_1???_????_????: w_code = 4'd11;
                    16'b0000_01??_????_????: w_code = 4'd10;
                    16'b0000_001?_????_????: w_code = 4'd9;
                    16'b0000_0001_????_????: w_code = 4'd8;
                    16'b0000_0000_1???_????: w_code = 4'd7;
                    16'b0000_0000_01??_????: w_code = 4'd6;
                    16'b0000_0000_001?_????: w_code = 4'd5;
                    16'b0000_0000_0001_????: w_code = 4'd4;
                    16'b0000_0000_0000_1???: w_code = 4'd3;
                    16'b0000_0000_0000_01??: w_code = 4'd2;
                    16'b0000_0000_0000_001?: w_code = 4'd1;
                    16'b0000_0000_0000_0001: w_code = 4'd0;
                    default:                 w_code = 4'd0;
                endcase
            end
        end
    endgenerate

    // Pending-vector properties used by both the FSM and the outputs.
    always_comb begin
        w_pend_nz    = |r_pend;
        w_single     = w_pend_nz && ((r_pend & (r_pend - 16'd1)) == 16'd0);
        w_clear_mask = 16'd1 << w_code;
    end

    // State register: reset discards any pending bits and the drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_pend      <= 16'd0;
            r_zero_drop <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_zero_drop <= w_zero_drop_nxt;
        end
    end

    // Next-state logic: capture in IDLE, clear one bit per consumed code in SCAN.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_zero_drop_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    if (req_in != 16'd0) begin
                        w_pend_nxt  = req_in;
                        w_state_nxt = c_st_scan;
                    end else begin
                        w_zero_drop_nxt = 1'b1;
                    end
                end
            end
            c_st_scan: begin
                // An empty pending vector here is a corruption; fall back quietly.
                if (!w_pend_nz) begin
                    w_state_nxt = c_st_idle;
                end else if (w_fire) begin
                    w_pend_nxt = r_pend & ~w_clear_mask;
                    if (w_single) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_pend_nxt  = 16'd0;
            end
        endcase
    end

    // Outputs: in_ready is masked by rst so it is low for the whole reset.
    always_comb begin
        in_ready  = !rst && (r_state == c_st_idle);
        out_valid = (r_state == c_st_scan) && w_pend_nz;
        code_out  = out_valid ? w_code : 4'd0;
        out_last  = out_valid && w_single;
        zero_drop = r_zero_drop;
        w_fire    = out_valid && out_ready;
    end

`ifdef ENCODER_PARITY_EN
    // Parity follows code_out and is forced low while no code is offered.
    always_comb begin
        code_par = out_valid && (^code_out);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder_using_priority_casez.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_using_priority_casez
// Description : Self-checking bench for encoder_using_priority_casez. Expected
//               codes come from a bit-scan reference model held in a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_using_priority_casez;

    localparam int LOW_FIRST = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  code_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        zero_drop;
`ifdef ENCODER_PARITY_EN
    logic        code_par;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    encoder_using_priority_casez #(
        .LOW_FIRST (LOW_FIRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_out  (code_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero_drop (zero_drop)
`ifdef ENCODER_PARITY_EN
        ,
        .code_par  (code_par)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the codes a vector should produce, listed in priority order.
    function automatic void build_expected(input logic [15:0] v);
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            int b;
            b = (LOW_FIRST != 0) ? k : 15 - k;
            if (v[b]) exp_q.push_back(b);
        end
    endfunction

    // Offer one vector, then drain it. hold0 >= 0: out_ready low for hold0
    // cycles then high; hold0 < 0: random out_ready. junk drives in_valid
    // noise during the scan, which must be ignored.
    task automatic run_vector(input logic [15:0] v, input int hold0, input bit junk);
        int  guard;
        int  cyc;
        int  code;
        bit  last;
        bit  rdy;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("wait_in_ready", 16'(in_ready), 16'd1);
        req_in   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        req_in   = 16'($urandom);
        build_expected(v);
        if (v == 16'd0) begin
            chk("zero_drop_pulse", 16'(zero_drop), 16'd1);
            chk("zero_out_valid", 16'(out_valid), 16'd0);
            chk("zero_in_ready", 16'(in_ready), 16'd1);
            tick();
            chk("zero_drop_clear", 16'(zero_drop), 16'd0);
            chk("zero_out_valid2", 16'(out_valid), 16'd0);
            return;
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (hold0 >= 0) rdy = (cyc >= hold0);
            else            rdy = ($urandom_range(0, 3) != 0);
            out_ready = rdy;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                req_in   = 16'($urandom);
            end
            #1;
            code = exp_q[0];
            last = (exp_q.size() == 1);
            chk("out_valid", 16'(out_valid), 16'd1);
            chk("code_out", 16'(code_out), 16'(code));
            chk("out_last", 16'(out_last), 16'(last));
            chk("in_ready_scan", 16'(in_ready), 16'd0);
`ifdef ENCODER_PARITY_EN
            chk("code_par", 16'(code_par), 16'($countones(16'(code)) % 2));
`endif
            if (rdy) void'(exp_q.pop_front());
            tick();
            cyc++;
        end
        chk("drain_bound", 16'(exp_q.size()), 16'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("done_out_valid", 16'(out_valid), 16'd0);
        chk("done_in_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        logic [15:0] v;
        int          sel;
        int          guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        req_in    = 16'd0;
        out_ready = 1'b0;

        // Reset held for two cycles.
        tick();
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_code_out", 16'(code_out), 16'd0);
        chk("rst_zero_drop", 16'(zero_drop), 16'd0);
        chk("rst_out_last", 16'(out_last), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 16'(in_ready), 16'd1);
        chk("rel_out_valid", 16'(out_valid), 16'd0);

        // Directed vectors: single bit, multi-bit, backpressure, zero.
        run_vector(16'h0001, 0, 1'b0);
        run_vector(16'h8421, 0, 1'b0);
        run_vector(16'h0300, 3, 1'b0);
        run_vector(16'h0000, 0, 1'b0);
        run_vector(16'h8000, 0, 1'b0);

        // Reset in the middle of a scan.
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        req_in   = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        build_expected(16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            chk("mid_out_valid", 16'(out_valid), 16'd1);
            chk("mid_code_out", 16'(code_out), 16'(exp_q[0]));
            void'(exp_q.pop_front());
            tick();
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_code_out", 16'(code_out), 16'd0);
        chk("mid_rst_in_ready", 16'(in_ready), 16'd0);
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("mid_rel_in_ready", 16'(in_ready), 16'd1);
        run_vector(16'h0010, 0, 1'b0);

        // Random vectors with random backpressure and in_valid noise.
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      v = 16'd0;
            else if (sel <= 3) v = 16'd1 << $urandom_range(0, 15);
            else if (sel == 4) v = 16'hFFFF;
            else               v = 16'($urandom) & 16'($urandom);
            run_vector(v, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
